// File: rtl/fp_unit_share_arbiter_if.sv
// Bundle of requester, shared FP unit and response signals for fp_unit_share_arbiter.
// The arbiter takes the slave view; the requesters plus the FP unit take the master view.
interface fp_unit_share_arbiter_if;
   logic        req0_valid;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic        req1_ready;
   logic        mux_select;
   logic        unit_valid;
   logic [15:0] unit_a;
   logic [15:0] unit_b;
   logic [15:0] unit_result;
   logic        resp0_valid;
   logic        resp1_valid;
   logic [15:0] resp_data;

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, unit_result,
      output req0_ready, req1_ready, mux_select, unit_valid, unit_a, unit_b,
             resp0_valid, resp1_valid, resp_data
   );

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, unit_result,
      input  req0_ready, req1_ready, mux_select, unit_valid, unit_a, unit_b,
             resp0_valid, resp1_valid, resp_data
   );
endinterface

// File: rtl/fp_unit_share_arbiter.sv
// Round-robin, burst-limited arbiter sharing one pipelined FP16 unit between two requesters,
// with a LAT-deep in-flight tag pipe that steers each unit result back to its issuer.
module fp_unit_share_arbiter #(
   parameter int LAT       = 3,
   parameter int MAX_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   fp_unit_share_arbiter_if.slave bus
);

   localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
   logic            last_q, last_d;
   logic [LAT-1:0]  trk_vld_q, trk_vld_d;
   logic [LAT-1:0]  trk_tag_q, trk_tag_d;
   logic            sel_s;
   logic            issue_s;

   // Next-state, burst accounting and in-flight pipe shift
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      last_d      = last_q;
      sel_s       = (state_q == GRANT1);
      issue_s     = ((state_q == GRANT0) && bus.req0_valid) ||
                    ((state_q == GRANT1) && bus.req1_valid);

      case (state_q)
         IDLE: begin
            if (bus.req0_valid && bus.req1_valid) begin
               state_d = last_q ? GRANT0 : GRANT1;
            end else if (bus.req0_valid) begin
               state_d = GRANT0;
            end else if (bus.req1_valid) begin
               state_d = GRANT1;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT0: begin
            if (!bus.req0_valid) begin
               state_d     = bus.req1_valid ? GRANT1 : IDLE;
               burst_cnt_d = {CW{1'b0}};
            end else begin
               last_d = 1'b0;
               if (burst_cnt_q == CNT_MAX) begin
                  burst_cnt_d = {CW{1'b0}};
                  state_d     = bus.req1_valid ? GRANT1 : GRANT0;
               end else begin
                  burst_cnt_d = burst_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                  state_d     = GRANT0;
               end
            end
         end
         GRANT1: begin
            if (!bus.req1_valid) begin
               state_d     = bus.req0_valid ? GRANT0 : IDLE;
               burst_cnt_d = {CW{1'b0}};
            end else begin
               last_d = 1'b1;
               if (burst_cnt_q == CNT_MAX) begin
                  burst_cnt_d = {CW{1'b0}};
                  state_d     = bus.req0_valid ? GRANT0 : GRANT1;
               end else begin
                  burst_cnt_d = burst_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                  state_d     = GRANT1;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            burst_cnt_d = {CW{1'b0}};
         end
      endcase

      trk_vld_d[0] = issue_s;
      trk_tag_d[0] = sel_s;
      for (int i = 1; i < LAT; i++) begin
         trk_vld_d[i] = trk_vld_q[i-1];
         trk_tag_d[i] = trk_tag_q[i-1];
      end
   end

   // Outputs decode from registered state; rst masks them so nothing leaks during reset
   always_comb begin
      bus.req0_ready  = (state_q == GRANT0) && !rst;
      bus.req1_ready  = (state_q == GRANT1) && !rst;
      bus.mux_select  = sel_s && !rst;
      bus.unit_valid  = issue_s && !rst;
      bus.unit_a      = sel_s ? bus.req1_a : bus.req0_a;
      bus.unit_b      = sel_s ? bus.req1_b : bus.req0_b;
      bus.resp0_valid = trk_vld_q[LAT-1] && !trk_tag_q[LAT-1] && !rst;
      bus.resp1_valid = trk_vld_q[LAT-1] &&  trk_tag_q[LAT-1] && !rst;
      bus.resp_data   = bus.unit_result;
   end

   // State, burst, round-robin pointer and in-flight pipe registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         burst_cnt_q <= {CW{1'b0}};
         last_q      <= 1'b1;
         trk_vld_q   <= {LAT{1'b0}};
         trk_tag_q   <= {LAT{1'b0}};
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         last_q      <= last_d;
         trk_vld_q   <= trk_vld_d;
         trk_tag_q   <= trk_tag_d;
      end
   end

endmodule

// File: tb/tb_fp_unit_share_arbiter.sv
// Directed bench: queue scoreboard of expected responses plus per-cycle issue-pattern logs.
module tb_fp_unit_share_arbiter;

   localparam int LAT = 3;
   localparam int MB  = 4;

   typedef struct {
      logic        tag;
      logic [15:0] data;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   idx0     = 0;
   int   idx1     = 0;
   exp_t sb[$];
   int   log_q[$];
   logic [1:0] rlog[$];

   logic [15:0] cap_r;
   logic [15:0] pipe_r [LAT];
   logic [15:0] u1_res = 16'hA000;

   always #5 clk = ~clk;

   fp_unit_share_arbiter_if bus ();
   fp_unit_share_arbiter_if bus1 ();

   fp_unit_share_arbiter #(.LAT(LAT), .MAX_BURST(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fp_unit_share_arbiter #(.LAT(1), .MAX_BURST(2)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   function automatic logic [15:0] fpu_model(input logic [15:0] a, input logic [15:0] b);
      return a ^ {b[7:0], b[15:8]} ^ 16'h1234;
   endfunction

   // Stand-in FP unit: operands seen during cycle t come back during cycle t+LAT
   always @(negedge clk) begin
      cap_r <= bus.unit_valid ? fpu_model(bus.unit_a, bus.unit_b) : 16'hDEAD;
   end

   always @(posedge clk) begin
      pipe_r[0] <= cap_r;
      for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
      cyc    <= cyc + 1;
      u1_res <= 16'hA000 ^ (cyc[15:0] + 16'd1);
   end

   assign bus.unit_result  = pipe_r[LAT-1];
   assign bus1.unit_result = u1_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ops();
      bus.req0_a = 16'h3C00 + idx0[15:0];
      bus.req0_b = 16'h4000 ^ idx0[15:0];
      bus.req1_a = 16'h5000 + idx1[15:0];
      bus.req1_b = 16'hC000 ^ idx1[15:0];
   endtask

   // Drive n0/n1 operations (req1 starts d1 cycles late), logging issues and pushing expectations
   task automatic stream(input int n0, input int n1, input int d1);
      int   r0 = n0;
      int   r1 = n1;
      int   k  = 0;
      exp_t e;
      log_q.delete();
      rlog.delete();
      set_ops();
      bus.req0_valid = (r0 > 0);
      bus.req1_valid = (r1 > 0) && (d1 == 0);
      while ((r0 > 0 || r1 > 0) && k < 200) begin
         @(negedge clk);
         log_q.push_back(bus.unit_valid ? int'(bus.mux_select) : 2);
         rlog.push_back({bus.req1_ready, bus.req0_ready});
         if (bus.req0_valid && bus.req0_ready) begin
            e.tag = 1'b0; e.data = fpu_model(bus.req0_a, bus.req0_b); e.due = cyc + LAT;
            sb.push_back(e);
            r0--; idx0++;
         end
         if (bus.req1_valid && bus.req1_ready) begin
            e.tag = 1'b1; e.data = fpu_model(bus.req1_a, bus.req1_b); e.due = cyc + LAT;
            sb.push_back(e);
            r1--; idx1++;
         end
         @(posedge clk);
         #1;
         k++;
         set_ops();
         bus.req0_valid = (r0 > 0);
         bus.req1_valid = (r1 > 0) && (k >= d1);
      end
      chk("stream_timeout", 32'(k < 200), 32'd1);
   endtask

   // Response monitor: every resp pulse must match the oldest expectation, on its due cycle
   initial begin
      exp_t m;
      forever begin
         @(negedge clk);
         if (bus.resp0_valid || bus.resp1_valid) begin
            chk("resp_onehot", 32'(bus.resp0_valid & bus.resp1_valid), 32'd0);
            chk("resp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               m = sb.pop_front();
               chk("resp_tag", 32'(bus.resp1_valid), 32'(m.tag));
               chk("resp_data", 32'(bus.resp_data), 32'(m.data));
               chk("resp_cycle", cyc, m.due);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_d[9] = '{2, 0, 0, 0, 0, 1, 1, 2, 0};

      rst = 1'b1;
      bus.req0_valid  = 1'b0;
      bus.req1_valid  = 1'b0;
      set_ops();
      bus1.req0_valid = 1'b0;
      bus1.req1_valid = 1'b0;
      bus1.req0_a     = 16'h1111;
      bus1.req0_b     = 16'h2222;
      bus1.req1_a     = 16'h3333;
      bus1.req1_b     = 16'h4444;

      idle(2);
      @(negedge clk);
      chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      chk("rst_resp", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      @(posedge clk);
      #1;

      // Single requester, six operations
      stream(6, 0, 0);
      chk("A_len", log_q.size(), 32'd7);
      chk("A_idle_cycle", log_q[0], 32'd2);
      for (int i = 1; i < 7; i++) chk("A_issue0", log_q[i], 32'd0);
      idle(6);
      chk("A_drain", sb.size(), 32'd0);

      // Drop mid-burst to IDLE, then burst count restarts from zero
      stream(2, 0, 0);
      chk("D_len", log_q.size(), 32'd3);
      chk("D_idle_cycle", log_q[0], 32'd2);
      idle(2);
      stream(5, 2, 1);
      chk("D2_len", log_q.size(), 32'd9);
      for (int i = 0; i < 9; i++) chk("D2_pattern", log_q[i], exp_d[i]);
      idle(6);
      chk("D_drain", sb.size(), 32'd0);

      // Alternating single operations
      for (int r = 0; r < 2; r++) begin
         stream(1, 0, 0);
         chk("C_bubble0", log_q[0], 32'd2);
         chk("C_issue0", log_q[1], 32'd0);
         stream(0, 1, 0);
         chk("C_bubble1", log_q[0], 32'd2);
         chk("C_issue1", log_q[1], 32'd1);
      end
      idle(6);
      chk("C_drain", sb.size(), 32'd0);

      // Reset with three operations in flight, then both requesters contend
      stream(3, 0, 0);
      rst = 1'b1;
      sb.delete();
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      @(negedge clk);
      chk("R_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      chk("R_unit_valid", 32'(bus.unit_valid), 32'd0);
      chk("R_mux", 32'(bus.mux_select), 32'd0);
      chk("R_resp", 32'({bus.resp1_valid, bus.resp0_valid}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      stream(12, 12, 0);
      chk("B_len", log_q.size(), 32'd25);
      chk("B_idle_cycle", log_q[0], 32'd2);
      chk("B_idle_ready", 32'(rlog[0]), 32'd0);
      for (int k = 0; k < 24; k++) chk("B_pattern", log_q[k+1], 32'((k / 4) % 2));
      idle(6);
      chk("B_drain", sb.size(), 32'd0);

      // LAT=1 instance: response one cycle after issue, data straight from unit_result
      bus1.req0_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("L1_issue", 32'(bus1.unit_valid), 32'(k >= 1 && k <= 3));
         chk("L1_resp0", 32'(bus1.resp0_valid), 32'(k >= 2 && k <= 4));
         chk("L1_resp1", 32'(bus1.resp1_valid), 32'd0);
         if (k >= 2 && k <= 4) chk("L1_data", 32'(bus1.resp_data), 32'(16'hA000 ^ cyc[15:0]));
         @(posedge clk);
         #1;
         if (k == 3) bus1.req0_valid = 1'b0;
      end

      chk("final_sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
